// File: rtl/mar_burst_gen_if.sv
// Address bus between the memory address register and its consumer.
// The producer presents addr with addr_valid, and the consumer accepts
// it with addr_ready.
//   addr        AW bits  current address
//   addr_valid  1 bit    addr is a live burst beat
//   addr_ready  1 bit    consumer accepts the presented address
// Modports: master (address producer), slave (address consumer).
interface mar_burst_gen_if #(
    parameter int AW = 8
);
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;

    modport master (
        output addr,
        output addr_valid,
        input  addr_ready
    );

    modport slave (
        input  addr,
        input  addr_valid,
        output addr_ready
    );
endinterface

// File: rtl/mar_burst_gen.sv
// Memory address register with a gated multi-source load, stride stepping
// inside the window [0, limit], and autonomous address bursts.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   d_in            packed load sources; source i = d_in[i*AW +: AW]
//   sel             load source select (out-of-range select loads 0)
//   g               load strobe
//   g1_n, g2_n      active-low enables, both low to act
//   mode            00 hold, 01 increment, 10 decrement, 11 burst
//   step, start     single-step request / burst start
//   abort           cancel a burst in progress
//   stride, limit   step size and inclusive upper window bound
//   burst_len       number of beats in a burst
//   bus (master)    addr / addr_valid / addr_ready handshake
//   busy            FSM is in BURST
//   wrap            one-cycle pulse when the last update wrapped
//   done            one-cycle pulse when a burst completes or is aborted
module mar_burst_gen #(
    parameter int AW   = 8,
    parameter int NSRC = 4,
    parameter int LENW = 4,
    localparam int SW  = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   d_in,
    input  logic [SW-1:0]        sel,
    input  logic                 g,
    input  logic                 g1_n,
    input  logic                 g2_n,
    input  logic [1:0]           mode,
    input  logic                 step,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW-1:0]        stride,
    input  logic [AW-1:0]        limit,
    input  logic [LENW-1:0]      burst_len,
    mar_burst_gen_if.master      bus,
    output logic                 busy,
    output logic                 wrap,
    output logic                 done
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic            valid_q;
    logic [LENW-1:0] count;

    logic            en;
    logic [AW-1:0]   src;
    logic [AW:0]     sum;
    logic            inc_wrap;
    logic [AW-1:0]   inc_next;
    logic            dec_wrap;
    logic [AW-1:0]   dec_next;

    assign en             = ~g1_n & ~g2_n;
    assign bus.addr       = addr_q;
    assign bus.addr_valid = valid_q;

    // Source mux. A select value with no matching source falls through to
    // the zero default, so out-of-range selects load 0.
    always_comb begin
        src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SW'(i)) begin
                src = d_in[i*AW +: AW];
            end
        end
    end

    // Next-address candidates for both step directions. The sum is kept one
    // bit wider so a carry out of AW bits still counts as exceeding limit,
    // and an address loaded above limit wraps on its next increment.
    always_comb begin
        sum      = {1'b0, addr_q} + {1'b0, stride};
        inc_wrap = (sum > {1'b0, limit});
        inc_next = inc_wrap ? '0 : sum[AW-1:0];
        dec_wrap = (stride > addr_q);
        dec_next = dec_wrap ? limit : (addr_q - stride);
    end

    // Control FSM. All outputs are registered here. wrap and done default
    // low every cycle so each event yields exactly a one-cycle pulse. In
    // BURST only abort and the handshake matter; abort is checked first so
    // it beats a same-cycle handshake and leaves addr untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (g) begin
                            addr_q <= src;
                        end else if (mode == 2'b11 && start) begin
                            count   <= burst_len;
                            state   <= BURST;
                            busy    <= 1'b1;
                            valid_q <= (burst_len != '0);
                        end else if (mode == 2'b01 && step) begin
                            addr_q <= inc_next;
                            wrap   <= inc_wrap;
                        end else if (mode == 2'b10 && step) begin
                            addr_q <= dec_next;
                            wrap   <= dec_wrap;
                        end
                    end
                end
                BURST: begin
                    if (abort || count == '0) begin
                        valid_q <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (valid_q && bus.addr_ready) begin
                        addr_q <= inc_next;
                        wrap   <= inc_wrap;
                        count  <= count - LENW'(1);
                        if (count == LENW'(1)) begin
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mar_burst_gen.sv
// Self-checking bench for mar_burst_gen. Expected burst beat addresses are
// pushed to a queue when a burst is launched and popped as each handshake
// is observed on the bus.
module tb_mar_burst_gen;

    localparam int AW   = 8;
    localparam int NSRC = 4;
    localparam int LENW = 4;
    localparam int SW   = $clog2(NSRC);

    logic                clk;
    logic                rst;
    logic [NSRC*AW-1:0]  d_in;
    logic [SW-1:0]       sel;
    logic                g;
    logic                g1_n;
    logic                g2_n;
    logic [1:0]          mode;
    logic                step;
    logic                start;
    logic                abort;
    logic [AW-1:0]       stride;
    logic [AW-1:0]       limit;
    logic [LENW-1:0]     burst_len;
    logic                busy;
    logic                wrap;
    logic                done;

    mar_burst_gen_if #(.AW(AW)) bus ();

    mar_burst_gen #(
        .AW   (AW),
        .NSRC (NSRC),
        .LENW (LENW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .sel       (sel),
        .g         (g),
        .g1_n      (g1_n),
        .g2_n      (g2_n),
        .mode      (mode),
        .step      (step),
        .start     (start),
        .abort     (abort),
        .stride    (stride),
        .limit     (limit),
        .burst_len (burst_len),
        .bus       (bus.master),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    int compare_count  = 0;
    int mismatch_count = 0;
    logic [AW-1:0] expect_q[$];

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic g_v, input logic g1_v, input logic g2_v,
                                 input logic [1:0] mode_v, input logic step_v,
                                 input logic start_v);
        g     = g_v;
        g1_n  = g1_v;
        g2_n  = g2_v;
        mode  = mode_v;
        step  = step_v;
        start = start_v;
        tick();
    endtask

    function automatic logic [AW-1:0] model_inc(input logic [AW-1:0] a,
                                                input logic [AW-1:0] s,
                                                input logic [AW-1:0] lim);
        int total;
        total = int'(a) + int'(s);
        if (total > int'(lim)) return '0;
        return AW'(total);
    endfunction

    task automatic push_burst(input logic [AW-1:0] base, input logic [AW-1:0] s,
                              input logic [AW-1:0] lim, input int beats);
        logic [AW-1:0] a;
        a = base;
        for (int k = 0; k < beats; k++) begin
            expect_q.push_back(a);
            a = model_inc(a, s, lim);
        end
    endtask

    // Runs the handshake side of a burst: ready follows the pattern then
    // stays high; abort is raised once abort_after beats have been taken.
    task automatic run_burst(input logic [3:0] ready_pat, input int abort_after,
                             output int beats_seen);
        logic [AW-1:0] held;
        logic          was_stalled;
        logic          finished;
        finished   = 1'b0;
        beats_seen = 0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            bus.addr_ready = (cyc < 4) ? ready_pat[3 - cyc] : 1'b1;
            abort = (abort_after >= 0 && beats_seen == abort_after);
            was_stalled = bus.addr_valid && !bus.addr_ready;
            held = bus.addr;
            if (bus.addr_valid && bus.addr_ready && !abort) begin
                if (expect_q.size() == 0) begin
                    checkOutput("beat_unexpected", 32'(bus.addr), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("beat_addr", 32'(bus.addr), 32'(expect_q.pop_front()));
                end
                beats_seen++;
            end
            tick();
            if (was_stalled && !abort) checkOutput("stall_addr_stable", 32'(bus.addr), 32'(held));
            if (done) finished = 1'b1;
        end
        abort = 1'b0;
        bus.addr_ready = 1'b0;
        if (!finished) checkOutput("burst_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int beats;
        logic [AW-1:0] pre_abort;
        rst = 1'b1;
        d_in = '0; sel = '0; g = 1'b0; g1_n = 1'b1; g2_n = 1'b1;
        mode = 2'b00; step = 1'b0; start = 1'b0; abort = 1'b0;
        stride = '0; limit = 8'hFF; burst_len = '0;
        bus.addr_ready = 1'b0;
        #12;
        checkOutput("reset_addr", 32'(bus.addr), 32'h0);
        checkOutput("reset_valid", 32'(bus.addr_valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_wrap_done", 32'({wrap, done}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Load gating: one enable inactive blocks the load.
        d_in[2*AW +: AW] = 8'h5A;
        sel = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        checkOutput("load_gated", 32'(bus.addr), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("load_enabled", 32'(bus.addr), 32'h5A);

        // Step wrap in both directions plus plain steps.
        d_in[1*AW +: AW] = 8'h0E;
        sel = 2'd1;
        limit = 8'h0F;
        stride = 8'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        checkOutput("inc_wrap_addr", 32'(bus.addr), 32'h00);
        checkOutput("inc_wrap_pulse", 32'(wrap), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("wrap_one_cycle", 32'(wrap), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        checkOutput("dec_wrap_addr", 32'(bus.addr), 32'h0F);
        checkOutput("dec_wrap_pulse", 32'(wrap), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        checkOutput("dec_plain_addr", 32'(bus.addr), 32'h0D);
        checkOutput("dec_plain_nowrap", 32'(wrap), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        checkOutput("inc_plain_addr", 32'(bus.addr), 32'h0F);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        checkOutput("step_gated", 32'(bus.addr), 32'h0F);

        // Priority: load beats start; start with enables off is ignored.
        d_in[3*AW +: AW] = 8'h33;
        sel = 2'd3;
        burst_len = 4'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        checkOutput("prio_load_addr", 32'(bus.addr), 32'h33);
        checkOutput("prio_not_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        checkOutput("start_gated", 32'({busy, bus.addr_valid}), 32'h0);

        // Burst with backpressure.
        d_in[0 +: AW] = 8'h10;
        sel = 2'd0;
        limit = 8'hFF;
        stride = 8'd4;
        burst_len = 4'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push_burst(8'h10, 8'd4, 8'hFF, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        start = 1'b0;
        checkOutput("burst_busy", 32'(busy), 32'h1);
        checkOutput("burst_valid", 32'(bus.addr_valid), 32'h1);
        run_burst(4'b1011, -1, beats);
        checkOutput("burst_beats", 32'(beats), 32'd3);
        checkOutput("burst_done", 32'(done), 32'h1);
        checkOutput("burst_final_addr", 32'(bus.addr), 32'h1C);
        checkOutput("burst_valid_drop", 32'({busy, bus.addr_valid}), 32'h0);
        checkOutput("burst_queue_empty", 32'(expect_q.size()), 32'd0);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'h0);

        // Zero-length burst: done one cycle after entry, never valid.
        burst_len = 4'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        start = 1'b0;
        checkOutput("zero_entry_busy", 32'(busy), 32'h1);
        checkOutput("zero_entry_valid", 32'(bus.addr_valid), 32'h0);
        checkOutput("zero_entry_nodone", 32'(done), 32'h0);
        tick();
        checkOutput("zero_done", 32'(done), 32'h1);
        checkOutput("zero_exit", 32'({busy, bus.addr_valid}), 32'h0);

        // Abort after two beats of a five-beat burst; abort beats ready.
        d_in[0 +: AW] = 8'h20;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        burst_len = 4'd5;
        push_burst(8'h20, 8'd4, 8'hFF, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        start = 1'b0;
        pre_abort = 8'h28;
        run_burst(4'b1111, 2, beats);
        checkOutput("abort_beats", 32'(beats), 32'd2);
        checkOutput("abort_done", 32'(done), 32'h1);
        checkOutput("abort_addr_hold", 32'(bus.addr), 32'(pre_abort));
        checkOutput("abort_valid_drop", 32'({busy, bus.addr_valid}), 32'h0);
        checkOutput("abort_leftover", 32'(expect_q.size()), 32'd3);
        expect_q.delete();

        // Reset asserted mid-burst takes effect without waiting for a clock.
        burst_len = 4'd4;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        start = 1'b0;
        checkOutput("pre_reset_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_addr", 32'(bus.addr), 32'h0);
        checkOutput("midreset_valid_busy", 32'({busy, bus.addr_valid}), 32'h0);
        checkOutput("midreset_nodone", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", 32'({busy, bus.addr_valid, done}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
